control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the datapath's select/enable lines and ALU handshake.
//  Per instruction: fetch via a memory handshake, increment PC via the ALU, decode IR, then execute.
//  Execute covers R-format ALU ops (Ra <= Rb op Rc), MFHI/MFLO, NOP and HALT.
//  Sits beside the datapath: consumes IR and ALU finished, produces every Xout/Xin strobe.
// PARAMETERS
//  ALU_TIMEOUT  64  max cycles waited for alu_finished after alu_start before FAULT
//  OPW          5   opcode width, IR[31:27]
// PORTS
//  clock         in   1   single clock, all state updates on rising edge
//  clear         in   1   asynchronous, active-low reset
//  run           in   1   level; leaving IDLE requires run=1
//  ir            in   32  IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
//  mem_ready     in   1   memory data valid on TB input this cycle
//  alu_finished  in   1   ALU result valid on ALU_Z this cycle
//  bus_sel       out  24  one-hot: [23]TB [22:7]R15..R0 [6]PC [5]IR [4]RY [3]RZ [2]MAR [1]RHI [0]RLO
//  reg_in        out  23  write enables: [22:7]R15..R0 [6]PC [5]IR [4]RY [3]RZ [2]MAR [1]RHI [0]RLO
//  alu_op        out  4   ALU opSelect, valid and held from alu_start until finished
//  alu_start     out  1   one-cycle pulse
//  rz_capture    out  1   RZ loads ALU_Z this cycle
//  mem_read      out  1   read request at address MAR, held until mem_ready
//  halted        out  1   sticky, set by HALT
//  fault         out  1   sticky, set by illegal opcode or ALU timeout
// BEHAVIOUR
//  - clear=0: state IDLE; all outputs 0; timeout counter 0. Applies immediately, including mid-instruction.
//  - Moore decode, except IRin and rz_capture, which are gated by mem_ready and alu_finished.
//  - Invariant: at most one bus_sel bit high per cycle.
//  - IDLE:       run=1 -> FETCH_A.
//  - FETCH_A:    PCout, MARin -> FETCH_M.
//  - FETCH_M:    mem_read=1, held while waiting.
//                On a cycle with mem_ready=1: TBout and IRin, then -> PC_INC.
//  - PC_INC:     PCout, alu_op=INC, alu_start on first cycle only -> WAIT. Shared wait described below.
//  - PC_WB:      RZout, PCin -> DECODE.
//  - DECODE:     ALU opcode -> EX_A. MFHI/MFLO -> MV. NOP -> FETCH_A (run=0 -> IDLE).
//                HALT -> HALTED. Any other opcode -> FAULT.
//  - EX_A:       Rb out, RYin -> EX_OP.
//  - EX_OP:      Rc out held through the whole wait, because ALU B comes from the bus.
//                alu_start on first cycle, alu_op from opcode -> WAIT.
//  - EX_WB:      RZout, Ra in -> FETCH_A (run=0 -> IDLE).
//  - MV:         RHIout or RLOout, Ra in -> FETCH_A (run=0 -> IDLE). Ra=R0 is a legal target.
//  - HALTED:     halted=1, all strobes 0; exit only by reset. FAULT: same, with fault=1.
//  - Shared wait:
//      - alu_finished is sampled from the cycle after alu_start.
//      - alu_finished coincident with alu_start is ignored.
//      - Finished cycle: rz_capture=1, then -> PC_WB or EX_WB.
//      - Counter counts wait cycles; reaching ALU_TIMEOUT with no finished -> FAULT.
//  - Timing with zero-wait memory and 1-cycle ALU: 10 cycles from FETCH_A to the next FETCH_A.
//  - mem_ready outside FETCH_M and alu_finished outside a wait are ignored.
// STRUCTURE
//  - Package ctrl_pkg holds:
//      - opcode localparams: ADD SUB AND OR SHL SHR NOT NEG MFHI MFLO NOP HALT.
//      - ALU op codes, including INC.
//      - bus_sel/reg_in bit indices.
//      - state encoding.
//  - Sub-module alu_waiter: start pulse generation, finished sampling, timeout counter.
//    Outputs done and timeout to the main FSM.
//  - Main FSM plus one-hot output decode form the top level.
// TESTING
//  1. Assert clear=0 mid-EX_OP.
//     -> All outputs 0 immediately; after release with run=1, FETCH_A on the first edge.
//  2. ir=ADD R3,R1,R2; mem_ready same cycle; finished 1 cycle after start.
//     -> Exact 10-cycle strobe trace: R1out+RYin, R2out held, R3in with RZout.
//  3. mem_ready delayed 3 cycles.
//     -> mem_read high 4 cycles; IRin only in the mem_ready cycle; single bus driver every cycle.
//  4. alu_finished never asserted with ALU_TIMEOUT=8.
//     -> fault=1 after 8 wait cycles; strobes 0 thereafter.
//  5. Opcode 5'h1F.
//     -> fault=1 one cycle after DECODE. HALT opcode -> halted=1, no further fetch with run=1.
//  6. MFLO R0 followed by NOP with run dropped.
//     -> RLOout+R0in in one cycle, then IDLE after NOP.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer.
// Holds the opcode map, ALU operation codes, the bit positions of the
// bus_sel / reg_in strobe vectors, the FSM state encoding and a few small
// decode helpers used by the top level.
package ctrl_pkg;

  // Instruction opcodes, IR[31:27]
  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_SHL  = 5'h04;
  localparam logic [4:0] OP_SHR  = 5'h05;
  localparam logic [4:0] OP_NOT  = 5'h06;
  localparam logic [4:0] OP_NEG  = 5'h07;
  localparam logic [4:0] OP_MFHI = 5'h08;
  localparam logic [4:0] OP_MFLO = 5'h09;
  localparam logic [4:0] OP_NOP  = 5'h0A;
  localparam logic [4:0] OP_HALT = 5'h0B;

  // ALU opSelect codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_SHL = 4'h4;
  localparam logic [3:0] ALU_SHR = 4'h5;
  localparam logic [3:0] ALU_NOT = 4'h6;
  localparam logic [3:0] ALU_NEG = 4'h7;
  localparam logic [3:0] ALU_INC = 4'h8;

  // Strobe bit positions; bus_sel and reg_in share indices 0..22,
  // bus_sel adds the TB driver at 23.
  localparam int B_RLO = 0;
  localparam int B_RHI = 1;
  localparam int B_MAR = 2;
  localparam int B_RZ  = 3;
  localparam int B_RY  = 4;
  localparam int B_IR  = 5;
  localparam int B_PC  = 6;
  localparam int B_R0  = 7;
  localparam int B_TB  = 23;

  // FSM state encoding
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH_A = 4'd1;
  localparam logic [3:0] S_FETCH_M = 4'd2;
  localparam logic [3:0] S_PC_INC  = 4'd3;
  localparam logic [3:0] S_PC_WB   = 4'd4;
  localparam logic [3:0] S_DECODE  = 4'd5;
  localparam logic [3:0] S_EX_A    = 4'd6;
  localparam logic [3:0] S_EX_OP   = 4'd7;
  localparam logic [3:0] S_EX_WB   = 4'd8;
  localparam logic [3:0] S_MV      = 4'd9;
  localparam logic [3:0] S_HALTED  = 4'd10;
  localparam logic [3:0] S_FAULT   = 4'd11;

  function automatic logic [23:0] bus_bit(input int idx);
    return 24'd1 << idx;
  endfunction

  function automatic logic [22:0] reg_bit(input int idx);
    return 23'd1 << idx;
  endfunction

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op <= OP_NEG);
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      OP_NOT:  return ALU_NOT;
      OP_NEG:  return ALU_NEG;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_waiter.sv
// ALU handshake helper for the control sequencer.
// While the FSM sits in an ALU state (active=1) it emits a single start
// pulse on the first cycle, then samples finished from the following cycle
// on. A wait-cycle counter raises timeout on the ALU_TIMEOUT-th wait cycle
// that sees no finished.
// Ports:
//   clock     in  rising-edge clock
//   clear     in  asynchronous active-low reset
//   active    in  FSM is in PC_INC or EX_OP
//   finished  in  ALU result valid this cycle
//   start     out one-cycle start pulse
//   done      out finished seen during the wait (not on the start cycle)
//   timeout   out wait budget exhausted without finished
module alu_waiter #(
  parameter int ALU_TIMEOUT = 64
) (
  input  logic clock,
  input  logic clear,
  input  logic active,
  input  logic finished,
  output logic start,
  output logic done,
  output logic timeout
);

  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ALU_TIMEOUT - 1);

  logic          busy;  // start already issued for the current ALU state
  logic [CW-1:0] cnt;   // wait cycles seen so far, excluding the current one

  assign start   = active & ~busy;
  // finished on the start cycle itself is ignored because busy is still 0
  assign done    = active & busy & finished;
  assign timeout = active & busy & ~finished & (cnt == LAST);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (active && !done && !timeout) begin
      busy <= 1'b1;
      if (busy) cnt <= cnt + 1'b1;
    end else begin
      busy <= 1'b0;
      cnt  <= '0;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the datapath.
// Sequences fetch (memory handshake), PC increment through the ALU, decode
// and execute of R-format ALU ops, MFHI/MFLO, NOP and HALT, and drives every
// bus driver select and register load strobe.
// Ports:
//   clock         in   rising-edge clock
//   clear         in   asynchronous active-low reset
//   run           in   level; permits leaving IDLE and continuing after an instruction
//   ir[31:0]      in   [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   mem_ready     in   memory data valid on TB this cycle
//   alu_finished  in   ALU_Z valid this cycle
//   bus_sel[23:0] out  one-hot bus driver: TB, R15..R0, PC, IR, RY, RZ, MAR, RHI, RLO
//   reg_in[22:0]  out  load enables: R15..R0, PC, IR, RY, RZ, MAR, RHI, RLO
//   alu_op[3:0]   out  ALU opSelect, held through the ALU wait
//   alu_start     out  one-cycle ALU start pulse
//   rz_capture    out  RZ loads ALU_Z
//   mem_read      out  read request at MAR, held until mem_ready
//   halted        out  HALT executed (sticky until reset)
//   fault         out  illegal opcode or ALU timeout (sticky until reset)
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int ALU_TIMEOUT = 64,
  parameter int OPW         = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        alu_finished,
  output logic [23:0] bus_sel,
  output logic [22:0] reg_in,
  output logic [3:0]  alu_op,
  output logic        alu_start,
  output logic        rz_capture,
  output logic        mem_read,
  output logic        halted,
  output logic        fault
);

  logic [3:0]     state;
  logic [3:0]     next;
  logic [OPW-1:0] opcode;
  logic [3:0]     ra;
  logic [3:0]     rb;
  logic [3:0]     rc;
  logic           active;
  logic           start;
  logic           done;
  logic           timeout;
  logic           unused_ir;

  assign opcode    = ir[31 -: OPW];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign active = (state == S_PC_INC) || (state == S_EX_OP);

  alu_waiter #(
    .ALU_TIMEOUT(ALU_TIMEOUT)
  ) u_waiter (
    .clock    (clock),
    .clear    (clear),
    .active   (active),
    .finished (alu_finished),
    .start    (start),
    .done     (done),
    .timeout  (timeout)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:    if (run) next = S_FETCH_A;
      S_FETCH_A: next = S_FETCH_M;
      S_FETCH_M: if (mem_ready) next = S_PC_INC;
      S_PC_INC: begin
        if (done)         next = S_PC_WB;
        else if (timeout) next = S_FAULT;
      end
      S_PC_WB:   next = S_DECODE;
      S_DECODE: begin
        if (is_alu_op(opcode))                           next = S_EX_A;
        else if (opcode == OP_MFHI || opcode == OP_MFLO) next = S_MV;
        else if (opcode == OP_NOP)                       next = run ? S_FETCH_A : S_IDLE;
        else if (opcode == OP_HALT)                      next = S_HALTED;
        else                                             next = S_FAULT;
      end
      S_EX_A:    next = S_EX_OP;
      S_EX_OP: begin
        if (done)         next = S_EX_WB;
        else if (timeout) next = S_FAULT;
      end
      S_EX_WB,
      S_MV:      next = run ? S_FETCH_A : S_IDLE;
      S_HALTED:  next = S_HALTED;
      S_FAULT:   next = S_FAULT;
      default:   next = S_FAULT;
    endcase
  end

  // Moore strobe decode; only the IR load and RZ capture look at the
  // handshake inputs so they fire exactly on the data-valid cycle.
  always_comb begin
    bus_sel    = '0;
    reg_in     = '0;
    alu_op     = ALU_ADD;
    alu_start  = 1'b0;
    rz_capture = 1'b0;
    mem_read   = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state)
      S_FETCH_A: begin
        bus_sel = bus_bit(B_PC);
        reg_in  = reg_bit(B_MAR);
      end
      S_FETCH_M: begin
        mem_read = 1'b1;
        bus_sel  = bus_bit(B_TB);
        reg_in   = mem_ready ? reg_bit(B_IR) : '0;
      end
      S_PC_INC: begin
        bus_sel    = bus_bit(B_PC);
        alu_op     = ALU_INC;
        alu_start  = start;
        rz_capture = done;
      end
      S_PC_WB: begin
        bus_sel = bus_bit(B_RZ);
        reg_in  = reg_bit(B_PC);
      end
      S_EX_A: begin
        bus_sel = bus_bit(B_R0 + int'(rb));
        reg_in  = reg_bit(B_RY);
      end
      S_EX_OP: begin
        // ALU B operand comes straight off the bus, so Rc stays driven
        bus_sel    = bus_bit(B_R0 + int'(rc));
        alu_op     = alu_code(opcode);
        alu_start  = start;
        rz_capture = done;
      end
      S_EX_WB: begin
        bus_sel = bus_bit(B_RZ);
        reg_in  = reg_bit(B_R0 + int'(ra));
      end
      S_MV: begin
        bus_sel = (opcode == OP_MFHI) ? bus_bit(B_RHI) : bus_bit(B_RLO);
        reg_in  = reg_bit(B_R0 + int'(ra));
      end
      S_HALTED: halted = 1'b1;
      S_FAULT:  fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed strobe traces.
module tb_control_sequencer;

  // Expected strobe patterns
  localparam logic [23:0] X_PC  = 24'h000040;
  localparam logic [23:0] X_TB  = 24'h800000;
  localparam logic [23:0] X_RZ  = 24'h000008;
  localparam logic [23:0] X_RLO = 24'h000001;
  localparam logic [23:0] X_R1  = 24'h000100;
  localparam logic [23:0] X_R2  = 24'h000200;
  localparam logic [23:0] X_R6  = 24'h002000;
  localparam logic [23:0] X_R7  = 24'h004000;
  localparam logic [22:0] L_MAR = 23'h000004;
  localparam logic [22:0] L_IR  = 23'h000020;
  localparam logic [22:0] L_PC  = 23'h000040;
  localparam logic [22:0] L_RY  = 23'h000010;
  localparam logic [22:0] L_R0  = 23'h000080;
  localparam logic [22:0] L_R3  = 23'h000400;

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic        alu_finished;
  logic [23:0] bus_sel;
  logic [22:0] reg_in;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic        rz_capture;
  logic        mem_read;
  logic        halted;
  logic        fault;

  int n_chk;
  int n_pass;

  control_sequencer #(
    .ALU_TIMEOUT(8),
    .OPW        (5)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .run          (run),
    .ir           (ir),
    .mem_ready    (mem_ready),
    .alu_finished (alu_finished),
    .bus_sel      (bus_sel),
    .reg_in       (reg_in),
    .alu_op       (alu_op),
    .alu_start    (alu_start),
    .rz_capture   (rz_capture),
    .mem_read     (mem_read),
    .halted       (halted),
    .fault        (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // One clock cycle: drive handshake inputs after the edge, then check
  task automatic cyc(input string t, input bit mr, input bit af,
                     input logic [23:0] eb, input logic [22:0] er,
                     input bit es, input bit ez, input bit em,
                     input logic [1:0] ehf);
    @(posedge clock); #1;
    mem_ready    = mr;
    alu_finished = af;
    #1;
    chk({t, ".bus"},   32'(bus_sel), 32'(eb));
    chk({t, ".reg"},   32'(reg_in), 32'(er));
    chk({t, ".start"}, 32'(alu_start), 32'(es));
    chk({t, ".rz"},    32'(rz_capture), 32'(ez));
    chk({t, ".mrd"},   32'(mem_read), 32'(em));
    chk({t, ".hf"},    32'({halted, fault}), 32'(ehf));
    chk({t, ".drv"},   32'($countones(bus_sel) <= 1), 32'd1);
  endtask

  task automatic restart();
    @(posedge clock); #1;
    clear        = 1'b0;
    mem_ready    = 1'b0;
    alu_finished = 1'b0;
    #1;
    clear = 1'b1;
    run   = 1'b1;
  endtask

  // FETCH_A through DECODE; noise drives handshakes where they must be ignored
  task automatic fetch(input string t, input int delay, input bit noise, input bit drop_run);
    cyc({t, ".fa"}, noise, 1'b0, X_PC, L_MAR, 0, 0, 0, 2'b00);
    if (drop_run) run = 1'b0;
    for (int i = 0; i < delay; i++)
      cyc({t, ".fmw"}, 1'b0, 1'b0, X_TB, '0, 0, 0, 1, 2'b00);
    cyc({t, ".fm"}, 1'b1, 1'b0, X_TB, L_IR, 0, 0, 1, 2'b00);
    cyc({t, ".inc"}, 1'b0, noise, X_PC, '0, 1, 0, 0, 2'b00);
    chk({t, ".incop"}, 32'(alu_op), 32'h8);
    cyc({t, ".incfin"}, 1'b0, 1'b1, X_PC, '0, 0, 1, 0, 2'b00);
    chk({t, ".finop"}, 32'(alu_op), 32'h8);
    cyc({t, ".pcwb"}, 1'b0, noise, X_RZ, L_PC, 0, 0, 0, 2'b00);
    cyc({t, ".dec"}, 1'b0, 1'b0, '0, '0, 0, 0, 0, 2'b00);
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    clear        = 1'b0;
    run          = 1'b0;
    ir           = 32'h0;
    mem_ready    = 1'b0;
    alu_finished = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.bus",  32'(bus_sel), 32'h0);
    chk("rst.reg",  32'(reg_in), 32'h0);
    chk("rst.mrd",  32'(mem_read), 32'h0);
    chk("rst.hf",   32'({halted, fault}), 32'h0);

    // ADD R3,R1,R2: full 10-cycle instruction trace
    ir = {5'h00, 4'd3, 4'd1, 4'd2, 15'd0};
    restart();
    fetch("add", 0, 1'b0, 1'b0);
    cyc("add.exa",   1'b0, 1'b0, X_R1, L_RY, 0, 0, 0, 2'b00);
    cyc("add.exop",  1'b0, 1'b0, X_R2, '0,   1, 0, 0, 2'b00);
    chk("add.op", 32'(alu_op), 32'h0);
    cyc("add.exfin", 1'b0, 1'b1, X_R2, '0,   0, 1, 0, 2'b00);
    cyc("add.exwb",  1'b0, 1'b0, X_RZ, L_R3, 0, 0, 0, 2'b00);
    cyc("add.next",  1'b0, 1'b0, X_PC, L_MAR, 0, 0, 0, 2'b00);

    // NOP with 3-cycle memory latency and stray handshakes
    ir = {5'h0A, 27'd0};
    restart();
    fetch("dly", 3, 1'b1, 1'b0);
    cyc("dly.next", 1'b0, 1'b0, X_PC, L_MAR, 0, 0, 0, 2'b00);

    // SUB R5,R6,R7 with reset asserted during the EX_OP wait
    ir = {5'h01, 4'd5, 4'd6, 4'd7, 15'd0};
    restart();
    fetch("rst", 0, 1'b0, 1'b0);
    cyc("rst.exa",  1'b0, 1'b0, X_R6, L_RY, 0, 0, 0, 2'b00);
    cyc("rst.exop", 1'b0, 1'b0, X_R7, '0,   1, 0, 0, 2'b00);
    chk("rst.op", 32'(alu_op), 32'h1);
    cyc("rst.wait", 1'b0, 1'b0, X_R7, '0,   0, 0, 0, 2'b00);
    chk("rst.waitop", 32'(alu_op), 32'h1);
    #1;
    clear = 1'b0;
    #1;
    chk("rst.clr.bus",   32'(bus_sel), 32'h0);
    chk("rst.clr.reg",   32'(reg_in), 32'h0);
    chk("rst.clr.start", 32'(alu_start), 32'h0);
    chk("rst.clr.op",    32'(alu_op), 32'h0);
    clear = 1'b1;
    cyc("rst.after", 1'b0, 1'b0, X_PC, L_MAR, 0, 0, 0, 2'b00);

    // ALU never finishes: fault after 8 wait cycles
    ir = {5'h00, 4'd3, 4'd1, 4'd2, 15'd0};
    restart();
    cyc("to.fa",  1'b0, 1'b0, X_PC, L_MAR, 0, 0, 0, 2'b00);
    cyc("to.fm",  1'b1, 1'b0, X_TB, L_IR,  0, 0, 1, 2'b00);
    cyc("to.inc", 1'b0, 1'b0, X_PC, '0,    1, 0, 0, 2'b00);
    for (int i = 0; i < 8; i++)
      cyc("to.wait", 1'b0, 1'b0, X_PC, '0, 0, 0, 0, 2'b00);
    cyc("to.fault",  1'b0, 1'b0, '0, '0, 0, 0, 0, 2'b01);
    cyc("to.sticky", 1'b1, 1'b1, '0, '0, 0, 0, 0, 2'b01);

    // Illegal opcode 5'h1F
    ir = {5'h1F, 27'd0};
    restart();
    fetch("ill", 0, 1'b0, 1'b0);
    cyc("ill.fault", 1'b0, 1'b0, '0, '0, 0, 0, 0, 2'b01);

    // HALT: no further fetch with run held high
    ir = {5'h0B, 27'd0};
    restart();
    fetch("hlt", 0, 1'b0, 1'b0);
    cyc("hlt.set", 1'b0, 1'b0, '0, '0, 0, 0, 0, 2'b10);
    for (int i = 0; i < 3; i++)
      cyc("hlt.hold", 1'b1, 1'b1, '0, '0, 0, 0, 0, 2'b10);

    // MFLO R0, then NOP with run dropped -> IDLE
    ir = {5'h09, 4'd0, 23'd0};
    restart();
    fetch("mv", 0, 1'b0, 1'b0);
    cyc("mv.exe", 1'b0, 1'b0, X_RLO, L_R0, 0, 0, 0, 2'b00);
    ir = {5'h0A, 27'd0};
    fetch("nop", 0, 1'b0, 1'b1);
    cyc("nop.idle",  1'b0, 1'b0, '0, '0, 0, 0, 0, 2'b00);
    cyc("nop.idle2", 1'b1, 1'b1, '0, '0, 0, 0, 0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
